linebuffer3x3: RTL and testbench



---
 rtl/cnn_pkg.sv | 13 +
 rtl/linebuffer3x3_row_mem.sv | 26 ++
 rtl/linebuffer3x3.sv | 185 ++++++++++++++++++
 tb/tb_linebuffer3x3.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN front-end datapath.
package cnn_pkg;

    localparam int DATA_W = 8;
    localparam int K      = 3;
    localparam int TAPS   = K * K;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } lb_state_e;

endpackage

// File: rtl/linebuffer3x3_row_mem.sv
// Single-port row memory. The read is combinational, so it returns the old
// contents of the addressed entry in the same cycle that the write lands.
module row_mem #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Contents are not reset; the line buffer masks stale rows itself.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/linebuffer3x3.sv
// Streaming 3x3 window generator feeding the multiply-add tree.
//
//   state  | meaning
//   FILL   | rows 0..1 of a frame; row memories priming, no windows
//   STREAM | rows 2..IMG_H-1; a window per accepted pixel with col >= 2
module linebuffer3x3 #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = cnn_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pixel_valid,
    output logic [DATA_W-1:0] lb_ready0,
    output logic [DATA_W-1:0] lb_ready1,
    output logic [DATA_W-1:0] lb_ready2,
    output logic [DATA_W-1:0] lb_ready3,
    output logic [DATA_W-1:0] lb_ready4,
    output logic [DATA_W-1:0] lb_ready5,
    output logic [DATA_W-1:0] lb_ready6,
    output logic [DATA_W-1:0] lb_ready7,
    output logic [DATA_W-1:0] lb_ready8,
    output logic              result_rdy,
    output logic              pixel_end,
    output logic              frame_busy
);

    import cnn_pkg::*;

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN    = CW'(K - 1);
    localparam logic [RW-1:0] ROW_STREAM = RW'(K - 1);

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    lb_state_e         state_q, state_d;
    logic              busy_q, busy_d;
    logic              rdy_q, rdy_d;
    logic              end_q, end_d;
    logic [DATA_W-1:0] win_q [TAPS];
    logic [DATA_W-1:0] win_d [TAPS];

    logic [DATA_W-1:0] row1_rd;
    logic [DATA_W-1:0] row2_rd;
    logic              at_last;
    logic              win_valid;

    assign at_last = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // row1 holds the previous row, row2 the one before; row2 is refilled from
    // row1's outgoing entry so the pair behaves as a two-row delay line.
    row_mem #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W),
        .AW    (CW)
    ) u_row1 (
        .clk     (clk),
        .we_i    (pixel_valid),
        .addr_i  (col_q),
        .wdata_i (pixel_in),
        .rdata_o (row1_rd)
    );

    row_mem #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W),
        .AW    (CW)
    ) u_row2 (
        .clk     (clk),
        .we_i    (pixel_valid),
        .addr_i  (col_q),
        .wdata_i (row1_rd),
        .rdata_o (row2_rd)
    );

    // Raster position of the next pixel to be accepted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pixel_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Fill/stream sequencing; a window is only produced inside STREAM and
    // never while the column shifters still hold the previous row's tail.
    always_comb begin
        state_d   = state_q;
        win_valid = 1'b0;
        case (state_q)
            FILL: begin
                if (pixel_valid && (row_q == ROW_STREAM) && (col_q == '0)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                win_valid = pixel_valid && (col_q >= COL_WIN);
                if (pixel_valid && at_last) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Shift each window row left by one column on every accepted pixel.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            win_d[i] = win_q[i];
        end
        if (pixel_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r*K + c] = win_q[r*K + c + 1];
                end
            end
            win_d[K - 1]     = row2_rd;
            win_d[2*K - 1]   = row1_rd;
            win_d[TAPS - 1]  = pixel_in;
        end
    end

    // Output strobes and frame-in-progress flag.
    always_comb begin
        rdy_d  = win_valid;
        end_d  = win_valid && at_last;
        busy_d = busy_q;
        if (pixel_valid) begin
            busy_d = !at_last;
        end
    end

    // State register; a mid-frame reset drops the partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= FILL;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            end_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            state_q <= state_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            end_q   <= end_d;
            for (int i = 0; i < TAPS; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign lb_ready0  = win_q[0];
    assign lb_ready1  = win_q[1];
    assign lb_ready2  = win_q[2];
    assign lb_ready3  = win_q[3];
    assign lb_ready4  = win_q[4];
    assign lb_ready5  = win_q[5];
    assign lb_ready6  = win_q[6];
    assign lb_ready7  = win_q[7];
    assign lb_ready8  = win_q[8];
    assign result_rdy = rdy_q;
    assign pixel_end  = end_q;
    assign frame_busy = busy_q;

endmodule

// File: tb/tb_linebuffer3x3.sv
// Directed bench: a 5x4 instance for streaming/gap/reset cases and a 3x3
// instance for the single-window frame.
module tb_linebuffer3x3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] a_pix = '0;
    logic       a_val = 1'b0;
    logic [7:0] a_t0, a_t1, a_t2, a_t3, a_t4, a_t5, a_t6, a_t7, a_t8;
    logic       a_rdy, a_end, a_busy;

    logic [7:0] b_pix = '0;
    logic       b_val = 1'b0;
    logic [7:0] b_t0, b_t1, b_t2, b_t3, b_t4, b_t5, b_t6, b_t7, b_t8;
    logic       b_rdy, b_end, b_busy;

    logic [71:0] taps_a, taps_b;
    assign taps_a = {a_t0, a_t1, a_t2, a_t3, a_t4, a_t5, a_t6, a_t7, a_t8};
    assign taps_b = {b_t0, b_t1, b_t2, b_t3, b_t4, b_t5, b_t6, b_t7, b_t8};

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    linebuffer3x3 #(.IMG_W(5), .IMG_H(4), .DATA_W(8)) dut_a (
        .clk (clk), .rst (rst), .pixel_in (a_pix), .pixel_valid (a_val),
        .lb_ready0 (a_t0), .lb_ready1 (a_t1), .lb_ready2 (a_t2),
        .lb_ready3 (a_t3), .lb_ready4 (a_t4), .lb_ready5 (a_t5),
        .lb_ready6 (a_t6), .lb_ready7 (a_t7), .lb_ready8 (a_t8),
        .result_rdy (a_rdy), .pixel_end (a_end), .frame_busy (a_busy)
    );

    linebuffer3x3 #(.IMG_W(3), .IMG_H(3), .DATA_W(8)) dut_b (
        .clk (clk), .rst (rst), .pixel_in (b_pix), .pixel_valid (b_val),
        .lb_ready0 (b_t0), .lb_ready1 (b_t1), .lb_ready2 (b_t2),
        .lb_ready3 (b_t3), .lb_ready4 (b_t4), .lb_ready5 (b_t5),
        .lb_ready6 (b_t6), .lb_ready7 (b_t7), .lb_ready8 (b_t8),
        .result_rdy (b_rdy), .pixel_end (b_end), .frame_busy (b_busy)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input int pix, input logic v);
        a_pix = 8'(pix);
        a_val = v;
        b_val = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push_b(input int pix, input logic v);
        b_pix = 8'(pix);
        b_val = v;
        a_val = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Expected 5-wide window whose bottom-right pixel is (r, c) of a ramp.
    function automatic logic [71:0] mk_win(input int base, input int r, input int c);
        int b;
        b = base + (r - 2) * 5 + (c - 2);
        return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 5), 8'(b + 6), 8'(b + 7),
                8'(b + 10), 8'(b + 11), 8'(b + 12)};
    endfunction

    task automatic run_frame(input int base, input bit gaps);
        logic [71:0] last_w;
        bit          have_w;
        bit          win;
        bit          last;
        int          nrdy;
        last_w = '0;
        have_w = 1'b0;
        nrdy   = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                push_a(base + r * 5 + c, 1'b1);
                win  = (r >= 2) && (c >= 2);
                last = (r == 3) && (c == 4);
                nrdy += int'(a_rdy);
                check("rdy", a_rdy, win);
                check("end", a_end, last);
                check("busy", a_busy, !last);
                if (win) begin
                    last_w = mk_win(base, r, c);
                    have_w = 1'b1;
                    check("taps", taps_a, last_w);
                end
                if (gaps) begin
                    push_a(8'hEE, 1'b0);
                    nrdy += int'(a_rdy);
                    check("gap_rdy", a_rdy, 1'b0);
                    check("gap_end", a_end, 1'b0);
                    check("gap_busy", a_busy, !last);
                    if (win && have_w) begin
                        check("gap_hold", taps_a, last_w);
                    end
                end
            end
        end
        check("nwin", 72'(nrdy), 72'd6);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_taps_a", taps_a, 72'd0);
        check("rst_rdy_a", a_rdy, 1'b0);
        check("rst_end_a", a_end, 1'b0);
        check("rst_busy_a", a_busy, 1'b0);
        check("rst_taps_b", taps_b, 72'd0);
        check("rst_rdy_b", b_rdy, 1'b0);
        rst = 1'b0;
        push_a(0, 1'b0);

        // Continuous ramp, then a second frame back-to-back with +100 offset.
        run_frame(0, 1'b0);
        run_frame(100, 1'b0);
        push_a(8'hEE, 1'b0);
        check("idle_rdy", a_rdy, 1'b0);
        check("idle_hold", taps_a,
              {8'd107, 8'd108, 8'd109, 8'd112, 8'd113, 8'd114, 8'd117, 8'd118, 8'd119});

        // Ramp with pixel_valid toggling every other cycle.
        run_frame(0, 1'b1);
        check("toggle_last", taps_a,
              {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19});

        // Reset partway through a frame.
        for (int p = 0; p <= 12; p++) begin
            push_a(p, 1'b1);
        end
        check("first_win_rdy", a_rdy, 1'b1);
        check("first_win", taps_a,
              {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
        push_a(13, 1'b1);
        check("pre_rst_busy", a_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_taps", taps_a, 72'd0);
        check("mid_rst_rdy", a_rdy, 1'b0);
        check("mid_rst_end", a_end, 1'b0);
        check("mid_rst_busy", a_busy, 1'b0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        a_val = 1'b0;
        run_frame(0, 1'b0);

        // 3x3 frame: exactly one window, flagged as the frame's last.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                push_b(r * 3 + c, 1'b1);
                check("b_rdy", b_rdy, (r == 2) && (c == 2));
                check("b_end", b_end, (r == 2) && (c == 2));
                check("b_busy", b_busy, !((r == 2) && (c == 2)));
            end
        end
        check("b_taps", taps_b,
              {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
        push_b(8'hEE, 1'b0);
        check("b_after_rdy", b_rdy, 1'b0);
        check("b_after_end", b_end, 1'b0);
        check("b_hold", taps_b,
              {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
